// File: rtl/step_pkg.sv
// step_pkg: shared types and default sizing for the step-rate sequencer.
// Contents: FSM state enum, default period/step widths, default pulse length.
// No logic; imported by step_ramp_sequencer and step_period_timer.
package step_pkg;

  localparam int PW_DEF        = 21;  // period width, matches divider count_to
  localparam int SW_DEF        = 16;  // step count width
  localparam int PULSE_LEN_DEF = 4;   // step_out high time in clk cycles

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEL,
    ST_CRUISE,
    ST_DECEL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/step_period_timer.sv
// step_period_timer: free-running period counter with a step pulse stretcher.
// Latency: tick is combinational when cnt == period-1; pulse rises the cycle after tick.
// Backpressure: none; the counter holds at 0 while run is low.
// Ports: clk, rst (async, active-high), run (count enable), period (cycles per step),
//        tick (step event), pulse (PULSE_LEN-cycle stretched step pulse).
module step_period_timer
  import step_pkg::*;
#(
  parameter int PW        = PW_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [PW-1:0] period,
  output logic          tick,
  output logic          pulse
);

  localparam int            CW         = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN);

  logic [PW-1:0] cnt;
  logic [CW-1:0] pulse_cnt;

  // The period only changes on the tick edge, when cnt also returns to 0,
  // so cnt can never run past period-1.
  assign tick  = run && (cnt == period - PW'(1));
  assign pulse = (pulse_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // Keeps running with run low so the last pulse completes after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if (tick) begin
      pulse_cnt <= PULSE_LOAD;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/step_ramp_sequencer.sv
// step_ramp_sequencer: trapezoidal step-rate sequencer (accel / cruise / decel, abort).
// Latency: busy after the start edge; first step_out rises pst cycles after that edge.
// Backpressure: start is honoured only in IDLE; abort is latched and applied at the next step.
// Ports: clk, rst (async, active-high); command start, abort, dir_in, step_total,
//        period_start, period_min, period_dec; status step_out, dir_out, busy, done,
//        cur_period (feeds divider count_to), steps_left.
module step_ramp_sequencer
  import step_pkg::*;
#(
  parameter int PW        = PW_DEF,
  parameter int SW        = SW_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          dir_in,
  input  logic [SW-1:0] step_total,
  input  logic [PW-1:0] period_start,
  input  logic [PW-1:0] period_min,
  input  logic [PW-1:0] period_dec,
  output logic          step_out,
  output logic          dir_out,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] cur_period,
  output logic [SW-1:0] steps_left
);

  // Period floor leaves at least PULSE_LEN low cycles between pulses.
  localparam logic [PW-1:0] PMIN_FLOOR = PW'(2 * PULSE_LEN);

  state_t        state, state_nxt;
  logic [PW-1:0] pst_q, pmin_q, dec_q;
  logic [SW-1:0] acc;
  logic          abort_lat;
  logic          tick;

  logic [PW-1:0] pmin_in, pst_in;
  logic [SW-1:0] left_dec, acc_inc, acc_dec;
  logic [PW:0]   sub_w, add_w;
  logic [PW-1:0] up_period;
  logic          to_cruise, left_zero, acc_to_decel, cru_to_decel, dec_finish;
  logic          accept;

  // ---------------- command conditioning ----------------
  assign pmin_in = (period_min > PMIN_FLOOR) ? period_min : PMIN_FLOOR;
  assign pst_in  = (period_start > pmin_in) ? period_start : pmin_in;
  assign accept  = (state == ST_IDLE) && start;

  // ---------------- step arithmetic ----------------
  assign left_dec = steps_left - SW'(1);
  assign acc_inc  = acc + SW'(1);
  assign acc_dec  = (acc == '0) ? '0 : acc - SW'(1);

  // One extra bit so a large decrement shows up as a borrow and clamps to pmin.
  assign sub_w     = {1'b0, cur_period} - {1'b0, dec_q};
  assign to_cruise = sub_w[PW] || (sub_w[PW-1:0] <= pmin_q);
  // One extra bit so the slow-down add saturates at pst instead of wrapping.
  assign add_w     = {1'b0, cur_period} + {1'b0, dec_q};
  assign up_period = (add_w > {1'b0, pst_q}) ? pst_q : add_w[PW-1:0];

  // Decisions taken on the post-decrement step count.
  assign left_zero    = (left_dec == '0);
  assign acc_to_decel = (left_dec <= acc_inc) || abort_lat;
  assign cru_to_decel = (left_dec <= acc) || abort_lat;
  assign dec_finish   = left_zero || (abort_lat && (acc == '0));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (step_total == '0) ? ST_DONE : ST_ACCEL;
      end
      ST_ACCEL: begin
        if (tick) begin
          if (left_zero)         state_nxt = ST_DONE;
          else if (acc_to_decel) state_nxt = ST_DECEL;
          else if (to_cruise)    state_nxt = ST_CRUISE;
        end
      end
      ST_CRUISE: begin
        if (tick) begin
          if (left_zero)         state_nxt = ST_DONE;
          else if (cru_to_decel) state_nxt = ST_DECEL;
        end
      end
      ST_DECEL: begin
        if (tick && dec_finish) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_ACCEL, ST_CRUISE, ST_DECEL: busy = 1'b1;
      ST_DONE:                       done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- captured command and counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_period <= '0;
      steps_left <= '0;
      acc        <= '0;
      dir_out    <= 1'b0;
      pst_q      <= '0;
      pmin_q     <= '0;
      dec_q      <= '0;
      abort_lat  <= 1'b0;
    end else if (accept) begin
      cur_period <= pst_in;
      steps_left <= step_total;
      acc        <= '0;
      dir_out    <= dir_in;
      pst_q      <= pst_in;
      pmin_q     <= pmin_in;
      dec_q      <= period_dec;
      abort_lat  <= 1'b0;
    end else begin
      if (busy && abort) abort_lat <= 1'b1;
      if (tick) begin
        steps_left <= left_dec;
        case (state)
          ST_ACCEL: begin
            if (!left_zero && acc_to_decel) begin
              // acc++ then acc-- on the way into DECEL: net unchanged.
              cur_period <= up_period;
            end else begin
              acc <= acc_inc;
              if (!left_zero) cur_period <= to_cruise ? pmin_q : sub_w[PW-1:0];
            end
          end
          ST_CRUISE: begin
            if (!left_zero && cru_to_decel) begin
              cur_period <= up_period;
              acc        <= acc_dec;
            end
          end
          ST_DECEL: begin
            if (!dec_finish) begin
              cur_period <= up_period;
              acc        <= acc_dec;
            end
          end
          default: ;
        endcase
      end
    end
  end

  step_period_timer #(
    .PW        (PW),
    .PULSE_LEN (PULSE_LEN)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (busy),
    .period (cur_period),
    .tick   (tick),
    .pulse  (step_out)
  );

endmodule
